// File: rtl/ahb_manager_pkg.sv
// Shared AHB-Lite types and constants for the core-side AHB manager.
package ahb_manager_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [1:0] HSIZE_BYTE = 2'd0;
    localparam logic [1:0] HSIZE_HALF = 2'd1;
    localparam logic [1:0] HSIZE_WORD = 2'd2;

    typedef struct packed {
        logic       write;
        word_t      addr;
        logic [3:0] wen;
        word_t      store;
    } ahb_req_t;

    typedef struct packed {
        logic  valid;
        logic  write;
        word_t store;
        logic  err_local;
    } ahb_dslot_t;

endpackage

// File: rtl/ahb_manager_strobe_decode.sv
// Maps a core request (write, addr, byte strobes) onto AHB haddr/hsize.
// Loads are always whole-word; stores must use a naturally aligned strobe pattern.
module ahb_strobe_decode
    import ahb_manager_pkg::*;
(
    input  logic        i_write,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_wen,
    output logic [31:0] o_haddr,
    output logic [1:0]  o_hsize,
    output logic        o_illegal
);

    logic [1:0] w_offset;

    always_comb begin
        w_offset  = 2'd0;
        o_hsize   = HSIZE_WORD;
        o_illegal = 1'b0;
        if (i_write) begin
            case (i_wen)
                4'b0001: begin w_offset = 2'd0; o_hsize = HSIZE_BYTE; end
                4'b0010: begin w_offset = 2'd1; o_hsize = HSIZE_BYTE; end
                4'b0100: begin w_offset = 2'd2; o_hsize = HSIZE_BYTE; end
                4'b1000: begin w_offset = 2'd3; o_hsize = HSIZE_BYTE; end
                4'b0011: begin w_offset = 2'd0; o_hsize = HSIZE_HALF; end
                4'b1100: begin w_offset = 2'd2; o_hsize = HSIZE_HALF; end
                4'b1111: begin w_offset = 2'd0; o_hsize = HSIZE_WORD; end
                default: o_illegal = 1'b1;
            endcase
        end
    end

    // Low address bits come only from the strobe pattern, never from the core address.
    assign o_haddr = (i_addr & 32'hFFFF_FFFC) | {30'd0, w_offset};

endmodule

// File: rtl/ahb_manager.sv
// AHB-Lite manager: two-slot pipeline (address phase A, data phase D) turning
// core load/store requests into NONSEQ transfers with in-order responses.
module ahb_manager
    import ahb_manager_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [3:0]  i_req_wen,
    input  logic [31:0] i_req_store,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_load,
    output logic        o_resp_err,
    output logic [31:0] o_haddr,
    output htrans_t     o_htrans,
    output logic [1:0]  o_hsize,
    output logic        o_hwrite,
    output logic [31:0] o_hwdata,
    input  logic        i_hready,
    input  logic        i_hresp,
    input  logic [31:0] i_hrdata
);

    ahb_req_t    w_req;
    logic [31:0] w_haddr;
    logic [1:0]  w_hsize;
    logic        w_illegal;
    logic        w_a_load;
    logic        w_accept;
    logic        w_d_done;

    logic        r_a_valid;
    logic        r_a_write;
    logic        r_a_illegal;
    logic [31:0] r_a_store;
    logic [31:0] r_haddr;
    logic [1:0]  r_hsize;
    logic        r_hwrite;
    ahb_dslot_t  r_d;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_load;

    assign w_req.write = i_req_write;
    assign w_req.addr  = i_req_addr;
    assign w_req.wen   = i_req_wen;
    assign w_req.store = i_req_store;

    ahb_strobe_decode u_decode (
        .i_write   (w_req.write),
        .i_addr    (w_req.addr),
        .i_wen     (w_req.wen),
        .o_haddr   (w_haddr),
        .o_hsize   (w_hsize),
        .o_illegal (w_illegal)
    );

    // Slot A can take a new request when it is empty or is moving into D this cycle.
    assign w_a_load = ~r_a_valid | i_hready;
    assign w_accept = i_req_valid & w_a_load;
    assign w_d_done = i_hready & r_d.valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a_valid    <= 1'b0;
            r_a_write    <= 1'b0;
            r_a_illegal  <= 1'b0;
            r_a_store    <= '0;
            r_haddr      <= '0;
            r_hsize      <= HSIZE_BYTE;
            r_hwrite     <= 1'b0;
            r_d          <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_load  <= '0;
        end else begin
            if (i_hready) begin
                r_d.valid     <= r_a_valid;
                r_d.write     <= r_a_write;
                r_d.store     <= r_a_store;
                r_d.err_local <= r_a_illegal;
            end
            if (w_a_load) begin
                r_a_valid <= w_accept;
                if (w_accept) begin
                    r_a_write   <= w_req.write;
                    r_a_store   <= w_req.store;
                    r_a_illegal <= w_illegal;
                    // Bus address controls keep their last value across idle/illegal slots.
                    if (!w_illegal) begin
                        r_haddr  <= w_haddr;
                        r_hsize  <= w_hsize;
                        r_hwrite <= w_req.write;
                    end
                end
            end
            r_resp_valid <= w_d_done;
            r_resp_err   <= w_d_done & (i_hresp | r_d.err_local);
            r_resp_load  <= (w_d_done & ~r_d.write & ~r_d.err_local & ~i_hresp) ? i_hrdata : '0;
        end
    end

    assign o_req_ready  = w_a_load;
    assign o_htrans     = (r_a_valid & ~r_a_illegal) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign o_haddr      = r_haddr;
    assign o_hsize      = r_hsize;
    assign o_hwrite     = r_hwrite;
    assign o_hwdata     = (r_d.valid & r_d.write & ~r_d.err_local) ? r_d.store : '0;
    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_resp_err;
    assign o_resp_load  = r_resp_load;

endmodule
